mips_multicycle_fsm: RTL and testbench

Parametrised multicycle MIPS control FSM; owns its state register and drives all datapath control strobes.
Adds memory wait-state handshake, multi-cycle mult/div sequencing, configurable branch delay slot and illegal-opcode trap with exception vector.
Sits between the instruction register/memory interface and the multicycle datapath (PC, regfile, ALU, HI/LO unit).

---
 rtl/mips_multicycle_fsm_if.sv | 36 +++
 rtl/mips_multicycle_fsm.sv | 172 +++++++++++++++++
 tb/tb_mips_multicycle_fsm.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_fsm_if.sv
// mips_multicycle_fsm_if: instruction/memory status in, datapath control strobes out.
interface mips_multicycle_fsm_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic [3:0]  state;
  logic        pc_write;
  logic [1:0]  pc_write_cond;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_to_reg;
  logic        ir_write;
  logic [1:0]  pc_source;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic        md_start;
  logic        md_busy;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [31:0] stall_cnt;
  modport master (
    input  instr, mem_ready,
    output state, pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, md_start, md_busy,
           exc, exc_cause, stall_cnt
  );
  modport slave (
    output instr, mem_ready,
    input  state, pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, md_start, md_busy,
           exc, exc_cause, stall_cnt
  );
endinterface

// File: rtl/mips_multicycle_fsm.sv
// mips_multicycle_fsm: multicycle MIPS control FSM with memory wait states, mult/div sequencing and illegal-opcode trap.
// Define MC_STALL_CNT_EN to build the memory stall counter; otherwise stall_cnt is tied to 0.
module mips_multicycle_fsm #(
  parameter int MD_CYCLES  = 32,
  parameter bit DELAY_SLOT = 1
) (
  input logic cclk,
  input logic rst,
  mips_multicycle_fsm_if.master bus
);
  localparam int CW = $clog2(MD_CYCLES + 1);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_M, MEM_L, WRITE, MEM_S, EXEC_R, MEM_R,
    EXEC_B, EXEC_J, EXEC_I, MEM_I, DELAY, JAL, MULDIV, TRAP
  } state_t;
  state_t st, nxt, dst;
  logic [CW-1:0] cnt;
  logic [1:0] cause;
  logic [5:0] op, fn;
  logic r, rs, md, l, s, b, j, jal, i;
  logic [2:0] cls;
  assign op  = bus.instr[31:26];
  assign fn  = bus.instr[5:0];
  assign r   = op == 6'b000000;
  assign rs  = r && fn[5:2] == 4'b0000;
  assign md  = r && fn[5:2] == 4'b0110;
  assign l   = op == 6'b100011;
  assign s   = op == 6'b101011;
  assign b   = op[5:1] == 5'b00010;
  assign j   = op == 6'b000010;
  assign jal = op == 6'b000011;
  assign i   = op[5:3] == 3'b001;
  assign cls = r ? 3'd3 : b ? 3'd2 : (l | s) ? 3'd1 : 3'd0;
  assign dst = DELAY_SLOT ? DELAY : FETCH;
  assign bus.state     = st;
  assign bus.exc_cause = cause;
  always_ff @(posedge cclk or posedge rst)
    if (rst) begin
      st    <= FETCH;
      cnt   <= '0;
      cause <= 2'b00;
    end else begin
      st <= nxt;
      if (st == DECODE && md) cnt <= CW'(MD_CYCLES - 1);
      else if (st == MULDIV && cnt != '0) cnt <= cnt - 1'b1;
      if (st == TRAP) cause <= 2'b01;
    end
  always_comb begin
    nxt               = st;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 2'b00;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 2'b00;
    bus.ir_write      = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_op        = cls;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.md_start      = 1'b0;
    bus.md_busy       = 1'b0;
    bus.exc           = 1'b0;
    case (st)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'd4;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        nxt           = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 3'd4;
        nxt = md ? MULDIV : r ? EXEC_R : j ? EXEC_J : jal ? JAL : b ? EXEC_B :
              (l | s) ? EXEC_M : i ? EXEC_I : TRAP;
      end
      EXEC_M: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        nxt           = l ? MEM_L : MEM_S;
      end
      MEM_L: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        nxt          = bus.mem_ready ? WRITE : MEM_L;
      end
      WRITE: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        nxt            = FETCH;
      end
      MEM_S: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        nxt           = bus.mem_ready ? dst : MEM_S;
      end
      EXEC_R: begin
        bus.alu_src_a = rs ? 2'b10 : 2'b01;
        nxt           = MEM_R;
      end
      MEM_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        nxt           = FETCH;
      end
      EXEC_B: begin
        bus.alu_src_a     = 2'b01;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = {b & op[0], b & ~op[0]};
        nxt               = dst;
      end
      EXEC_J: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        nxt           = dst;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        nxt           = MEM_I;
      end
      MEM_I: begin
        bus.reg_write = 1'b1;
        nxt           = FETCH;
      end
      DELAY: nxt = FETCH;
      JAL: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        nxt            = dst;
      end
      MULDIV: begin
        bus.md_busy  = 1'b1;
        // counter is loaded with MD_CYCLES-1 on entry, so that value marks the first cycle
        bus.md_start = cnt == CW'(MD_CYCLES - 1);
        nxt          = cnt == '0 ? FETCH : MULDIV;
      end
      TRAP: begin
        bus.exc       = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b11;
        nxt           = FETCH;
      end
      default: nxt = TRAP;
    endcase
    if (rst) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.md_start  = 1'b0;
      bus.exc       = 1'b0;
    end
  end
`ifdef MC_STALL_CNT_EN
  logic [31:0] stall;
  always_ff @(posedge cclk or posedge rst)
    if (rst) stall <= '0;
    else if (!bus.mem_ready && (st == FETCH || st == MEM_L || st == MEM_S)) stall <= stall + 1'b1;
  assign bus.stall_cnt = stall;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// tb_mips_multicycle_fsm: scoreboard bench; u0 has the delay slot, u1 goes straight to FETCH.
module tb_mips_multicycle_fsm;
  logic cclk = 1'b0;
  logic rst;
  logic [31:0] instr;
  logic mem_ready;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        c1;
  } ent_t;
  ent_t q[$];
  ent_t e;
  mips_multicycle_fsm_if b0();
  mips_multicycle_fsm_if b1();
  assign b0.instr = instr;
  assign b0.mem_ready = mem_ready;
  assign b1.instr = instr;
  assign b1.mem_ready = mem_ready;
  mips_multicycle_fsm #(.MD_CYCLES(4), .DELAY_SLOT(1)) u0 (.cclk(cclk), .rst(rst), .bus(b0));
  mips_multicycle_fsm #(.MD_CYCLES(4), .DELAY_SLOT(0)) u1 (.cclk(cclk), .rst(rst), .bus(b1));
  always #5 cclk = ~cclk;

  task automatic push(input logic [31:0] ins, input logic rdy, input logic [3:0] s0,
                      input logic [3:0] s1, input logic c1);
    q.push_back({ins, rdy, s0, s1, c1});
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    instr = 32'h00221820;
    step();
    n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL reset_state got %h want 0", b0.state); end
    n_checks++; if ({b0.pc_write, b0.ir_write, b0.mem_read, b0.reg_write, b0.mem_write, b0.md_start, b0.exc} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0", {b0.pc_write, b0.ir_write, b0.mem_read, b0.reg_write, b0.mem_write, b0.md_start, b0.exc}); end
    n_checks++; if (b0.exc_cause !== 2'b00 || b0.stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs got cause=%b stall=%0d want 0/0", b0.exc_cause, b0.stall_cnt); end
    rst = 1'b0;
    mem_ready = 1'b0;
    step();
    n_checks++; if (b0.state !== 4'h0 || b0.mem_read !== 1'b1 || b0.ir_write !== 1'b0) begin
      n_fail++; $display("FAIL fetch_wait got state=%h rd=%b irw=%b want 0/1/0", b0.state, b0.mem_read, b0.ir_write); end
    rst = 1'b1;
    #1;
    n_checks++; if (b0.mem_read !== 1'b0 || b0.state !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_wait got rd=%b state=%h want 0/0", b0.mem_read, b0.state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h00221820, 1, 4'h0, 4'h0, 1); push(32'h00221820, 1, 4'h1, 4'h1, 1);
    push(32'h00221820, 1, 4'h6, 4'h6, 1); push(32'h00221820, 1, 4'h7, 4'h7, 1);
    push(32'h00021080, 1, 4'h0, 4'h0, 1); push(32'h00021080, 1, 4'h1, 4'h1, 1);
    push(32'h00021080, 1, 4'h6, 4'h6, 1); push(32'h00021080, 1, 4'h7, 4'h7, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL rtype_state got %h want %h", b0.state, e.s0); end
      n_checks++; if (b1.state !== e.s1) begin n_fail++; $display("FAIL rtype_state_u1 got %h want %h", b1.state, e.s1); end
      if (e.s0 == 4'h0) begin
        n_checks++; if (b0.ir_write !== 1'b1 || b0.pc_write !== 1'b1 || b0.alu_op !== 3'd4 || b0.alu_src_b !== 2'b01) begin
          n_fail++; $display("FAIL fetch_strobes got irw=%b pcw=%b op=%0d srcb=%b want 1/1/4/01", b0.ir_write, b0.pc_write, b0.alu_op, b0.alu_src_b); end
      end
      if (e.s0 == 4'h1) begin
        n_checks++; if (b0.alu_src_b !== 2'b11 || b0.alu_op !== 3'd4) begin
          n_fail++; $display("FAIL decode_strobes got srcb=%b op=%0d want 11/4", b0.alu_src_b, b0.alu_op); end
      end
      if (e.s0 == 4'h6) begin
        n_checks++; if (b0.alu_src_a !== (e.ins[5:2] == 4'b0 ? 2'b10 : 2'b01) || b0.alu_op !== 3'd3) begin
          n_fail++; $display("FAIL exec_r got srca=%b op=%0d for %h", b0.alu_src_a, b0.alu_op, e.ins); end
      end
      if (e.s0 == 4'h7) begin
        n_checks++; if (b0.reg_write !== 1'b1 || b0.reg_dst !== 2'b01) begin
          n_fail++; $display("FAIL mem_r got rw=%b dst=%b want 1/01", b0.reg_write, b0.reg_dst); end
      end
      step();
    end
    n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL rtype_end got %h want 0", b0.state); end
  endtask

  task automatic test_load_wait();
    int irw;
    logic [31:0] want_stall;
    irw = 0;
`ifdef MC_STALL_CNT_EN
    want_stall = 32'd5;
`else
    want_stall = 32'd0;
`endif
    do_reset();
    push(32'h8C220004, 0, 4'h0, 4'h0, 1); push(32'h8C220004, 0, 4'h0, 4'h0, 1);
    push(32'h8C220004, 0, 4'h0, 4'h0, 1); push(32'h8C220004, 1, 4'h0, 4'h0, 1);
    push(32'h8C220004, 1, 4'h1, 4'h1, 1); push(32'h8C220004, 1, 4'h2, 4'h2, 1);
    push(32'h8C220004, 0, 4'h3, 4'h3, 1); push(32'h8C220004, 0, 4'h3, 4'h3, 1);
    push(32'h8C220004, 1, 4'h3, 4'h3, 1); push(32'h8C220004, 1, 4'h4, 4'h4, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL load_state got %h want %h", b0.state, e.s0); end
      if (b0.ir_write === 1'b1) irw++;
      if (e.s0 == 4'h0 && !e.rdy) begin
        n_checks++; if (b0.pc_write !== 1'b0 || b0.mem_read !== 1'b1) begin
          n_fail++; $display("FAIL fetch_hold got pcw=%b rd=%b want 0/1", b0.pc_write, b0.mem_read); end
      end
      if (e.s0 == 4'h3) begin
        n_checks++; if (b0.mem_read !== 1'b1 || b0.iord !== 1'b1 || b0.reg_write !== 1'b0) begin
          n_fail++; $display("FAIL mem_l got rd=%b iord=%b rw=%b want 1/1/0", b0.mem_read, b0.iord, b0.reg_write); end
      end
      if (e.s0 == 4'h4) begin
        n_checks++; if (b0.reg_write !== 1'b1 || b0.mem_to_reg !== 2'b01) begin
          n_fail++; $display("FAIL write got rw=%b m2r=%b want 1/01", b0.reg_write, b0.mem_to_reg); end
      end
      step();
    end
    n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL load_end got %h want 0", b0.state); end
    n_checks++; if (irw != 1) begin n_fail++; $display("FAIL ir_write_pulses got %0d want 1", irw); end
    n_checks++; if (b0.stall_cnt !== want_stall) begin n_fail++; $display("FAIL stall_cnt got %0d want %0d", b0.stall_cnt, want_stall); end
  endtask

  task automatic test_store();
    do_reset();
    push(32'hAC220004, 1, 4'h0, 4'h0, 1); push(32'hAC220004, 1, 4'h1, 4'h1, 1);
    push(32'hAC220004, 1, 4'h2, 4'h2, 1); push(32'hAC220004, 0, 4'h5, 4'h5, 1);
    push(32'hAC220004, 1, 4'h5, 4'h5, 1); push(32'hAC220004, 1, 4'hC, 4'h0, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL store_state got %h want %h", b0.state, e.s0); end
      n_checks++; if (b1.state !== e.s1) begin n_fail++; $display("FAIL store_state_u1 got %h want %h", b1.state, e.s1); end
      if (e.s0 == 4'h2) begin
        n_checks++; if (b0.alu_src_a !== 2'b01 || b0.alu_src_b !== 2'b10 || b0.alu_op !== 3'd1) begin
          n_fail++; $display("FAIL exec_m got srca=%b srcb=%b op=%0d want 01/10/1", b0.alu_src_a, b0.alu_src_b, b0.alu_op); end
      end
      if (e.s0 == 4'h5) begin
        n_checks++; if (b0.mem_write !== 1'b1 || b0.iord !== 1'b1 || b0.mem_read !== 1'b0) begin
          n_fail++; $display("FAIL mem_s got wr=%b iord=%b rd=%b want 1/1/0", b0.mem_write, b0.iord, b0.mem_read); end
      end
      step();
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ins;
      ins = k == 0 ? 32'h10220003 : 32'h14220003;
      do_reset();
      push(ins, 1, 4'h0, 4'h0, 1); push(ins, 1, 4'h1, 4'h1, 1);
      push(ins, 1, 4'h8, 4'h8, 1); push(ins, 1, 4'hC, 4'h0, 1);
      while (q.size() > 0) begin
        e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
        n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL branch_state got %h want %h", b0.state, e.s0); end
        n_checks++; if (b1.state !== e.s1) begin n_fail++; $display("FAIL branch_state_u1 got %h want %h", b1.state, e.s1); end
        if (e.s0 == 4'h8) begin
          n_checks++; if (b0.pc_write_cond !== (k == 0 ? 2'b01 : 2'b10) || b0.pc_source !== 2'b01 || b0.alu_op !== 3'd2 || b0.alu_src_a !== 2'b01 || b0.pc_write !== 1'b0) begin
            n_fail++; $display("FAIL exec_b got pwc=%b src=%b op=%0d srca=%b pcw=%b (k=%0d)", b0.pc_write_cond, b0.pc_source, b0.alu_op, b0.alu_src_a, b0.pc_write, k); end
        end
        step();
      end
      n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL branch_end got %h want 0", b0.state); end
    end
  endtask

  task automatic test_jump();
    int rw;
    do_reset();
    push(32'h08000010, 1, 4'h0, 4'h0, 1); push(32'h08000010, 1, 4'h1, 4'h1, 1);
    push(32'h08000010, 1, 4'h9, 4'h9, 1); push(32'h08000010, 1, 4'hC, 4'h0, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL j_state got %h want %h", b0.state, e.s0); end
      n_checks++; if (b1.state !== e.s1) begin n_fail++; $display("FAIL j_state_u1 got %h want %h", b1.state, e.s1); end
      if (e.s0 == 4'h9) begin
        n_checks++; if (b0.pc_write !== 1'b1 || b0.pc_source !== 2'b10 || b0.reg_write !== 1'b0) begin
          n_fail++; $display("FAIL exec_j got pcw=%b src=%b rw=%b want 1/10/0", b0.pc_write, b0.pc_source, b0.reg_write); end
      end
      step();
    end
    rw = 0;
    do_reset();
    push(32'h0C000010, 1, 4'h0, 4'h0, 1); push(32'h0C000010, 1, 4'h1, 4'h1, 1);
    push(32'h0C000010, 1, 4'hD, 4'hD, 1); push(32'h0C000010, 1, 4'hC, 4'h0, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL jal_state got %h want %h", b0.state, e.s0); end
      n_checks++; if (b1.state !== e.s1) begin n_fail++; $display("FAIL jal_state_u1 got %h want %h", b1.state, e.s1); end
      if (b0.reg_write === 1'b1) rw++;
      if (e.s0 == 4'hD) begin
        n_checks++; if (b0.reg_write !== 1'b1 || b0.reg_dst !== 2'b10 || b0.mem_to_reg !== 2'b10 || b0.pc_write !== 1'b1 || b0.pc_source !== 2'b10) begin
          n_fail++; $display("FAIL jal got rw=%b dst=%b m2r=%b pcw=%b src=%b want 1/10/10/1/10", b0.reg_write, b0.reg_dst, b0.mem_to_reg, b0.pc_write, b0.pc_source); end
      end
      if (e.s0 == 4'hC) begin
        n_checks++; if (b0.pc_write !== 1'b0 || b0.pc_write_cond !== 2'b00) begin
          n_fail++; $display("FAIL delay got pcw=%b pwc=%b want 0/00", b0.pc_write, b0.pc_write_cond); end
      end
      step();
    end
    n_checks++; if (rw != 1) begin n_fail++; $display("FAIL jal_reg_write_cycles got %0d want 1", rw); end
  endtask

  task automatic test_itype();
    do_reset();
    push(32'h20220005, 1, 4'h0, 4'h0, 1); push(32'h20220005, 1, 4'h1, 4'h1, 1);
    push(32'h20220005, 1, 4'hA, 4'hA, 1); push(32'h20220005, 1, 4'hB, 4'hB, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL itype_state got %h want %h", b0.state, e.s0); end
      if (e.s0 == 4'hA) begin
        n_checks++; if (b0.alu_src_a !== 2'b01 || b0.alu_src_b !== 2'b10 || b0.alu_op !== 3'd0) begin
          n_fail++; $display("FAIL exec_i got srca=%b srcb=%b op=%0d want 01/10/0", b0.alu_src_a, b0.alu_src_b, b0.alu_op); end
      end
      if (e.s0 == 4'hB) begin
        n_checks++; if (b0.reg_write !== 1'b1 || b0.reg_dst !== 2'b00 || b0.mem_to_reg !== 2'b00) begin
          n_fail++; $display("FAIL mem_i got rw=%b dst=%b m2r=%b want 1/00/00", b0.reg_write, b0.reg_dst, b0.mem_to_reg); end
      end
      step();
    end
    n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL itype_end got %h want 0", b0.state); end
  endtask

  task automatic test_muldiv();
    int starts, busy, idx;
    starts = 0; busy = 0; idx = 0;
    do_reset();
    push(32'h00220018, 1, 4'h0, 4'h0, 1); push(32'h00220018, 1, 4'h1, 4'h1, 1);
    for (int k = 0; k < 4; k++) push(32'h00220018, 1, 4'hE, 4'hE, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL md_state got %h want %h", b0.state, e.s0); end
      if (b0.md_start === 1'b1) starts++;
      if (b0.md_busy === 1'b1) busy++;
      if (e.s0 == 4'hE) begin
        n_checks++; if (b0.md_start !== (idx == 0) || b0.reg_write !== 1'b0) begin
          n_fail++; $display("FAIL md_cycle%0d got start=%b rw=%b want %b/0", idx, b0.md_start, b0.reg_write, idx == 0); end
        idx++;
      end
      step();
    end
    n_checks++; if (b0.state !== 4'h0) begin n_fail++; $display("FAIL md_end got %h want 0", b0.state); end
    n_checks++; if (starts != 1 || busy != 4) begin n_fail++; $display("FAIL md_counts got start=%0d busy=%0d want 1/4", starts, busy); end
  endtask

  task automatic test_trap();
    do_reset();
    push(32'hFC000000, 1, 4'h0, 4'h0, 1); push(32'hFC000000, 1, 4'h1, 4'h1, 1);
    push(32'hFC000000, 1, 4'hF, 4'hF, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0) begin n_fail++; $display("FAIL trap_state got %h want %h", b0.state, e.s0); end
      if (e.s0 == 4'hF) begin
        n_checks++; if (b0.exc !== 1'b1 || b0.pc_write !== 1'b1 || b0.pc_source !== 2'b11 || b0.exc_cause !== 2'b00) begin
          n_fail++; $display("FAIL trap got exc=%b pcw=%b src=%b cause=%b want 1/1/11/00", b0.exc, b0.pc_write, b0.pc_source, b0.exc_cause); end
      end
      step();
    end
    n_checks++; if (b0.state !== 4'h0 || b0.exc !== 1'b0 || b0.exc_cause !== 2'b01) begin
      n_fail++; $display("FAIL trap_after got state=%h exc=%b cause=%b want 0/0/01", b0.state, b0.exc, b0.exc_cause); end
    push(32'h00220018, 1, 4'h0, 4'h0, 1); push(32'h00220018, 1, 4'h1, 4'h1, 1);
    push(32'h00220018, 1, 4'hE, 4'hE, 1); push(32'h00220018, 1, 4'hE, 4'hE, 1);
    while (q.size() > 0) begin
      e = q.pop_front(); instr = e.ins; mem_ready = e.rdy; #1;
      n_checks++; if (b0.state !== e.s0 || b0.exc_cause !== 2'b01) begin
        n_fail++; $display("FAIL md2_state got %h cause=%b want %h/01", b0.state, b0.exc_cause, e.s0); end
      step();
    end
    rst = 1'b1;
    #1;
    n_checks++; if (b0.state !== 4'h0 || b0.md_busy !== 1'b0 || b0.md_start !== 1'b0 || b0.exc_cause !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_md got state=%h busy=%b start=%b cause=%b want 0/0/0/00", b0.state, b0.md_busy, b0.md_start, b0.exc_cause); end
    n_checks++; if ({b0.pc_write, b0.ir_write, b0.mem_read, b0.reg_write, b0.mem_write, b0.exc} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_md_strobes got %b want 0", {b0.pc_write, b0.ir_write, b0.mem_read, b0.reg_write, b0.mem_write, b0.exc}); end
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    instr = 32'h0;
    test_reset();
    test_back_to_back();
    test_load_wait();
    test_store();
    test_branch();
    test_jump();
    test_itype();
    test_muldiv();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
